log_reader: RTL
===============

# log_reader

Drain side of the attestation event log. Walks the 37-bit log RAM from oldest to newest record, behind the write pointer produced by the logger. Decodes each record into type/pc/address/flag fields and presents it on a valid/ready stream to the report/UART path. Tracks how far the writer has lapped the reader and flags overflow.

## Interface

Parameters:
- `ADDR_W`, default 16: log RAM address width; depth is 2^ADDR_W.
- `DATA_W`, default 37: record width; fixed layout {type[2:0], pc[15:0], addr[15:0], en, wr}.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clr_ram`  in  1  synchronous log clear; same signal the writer sees.
- `log_wr_addr`  in  ADDR_W  writer's next-free index (write pointer).
- `ram_rd_en`  out  1  RAM read strobe.
- `ram_rd_addr`  out  ADDR_W  RAM read index.
- `ram_rd_data`  in  DATA_W  RAM read data, valid exactly 1 cycle after `ram_rd_en`.
- `rec_valid`  out  1  decoded record available.
- `rec_ready`  in  1  consumer accepts record.
- `rec_type`  out  3  record type (0 X_stack, 1 AC, 2 atomicity, 3 dma_AC, 4 dma_detect, 5 dma_X_stack).
- `rec_pc`  out  16  pc field.
- `rec_addr`  out  16  data/dma address field.
- `rec_en`  out  1  enable flag field.
- `rec_wr`  out  1  write flag field.
- `rec_idx`  out  ADDR_W  RAM index the record came from.
- `rec_bad`  out  1  type field is 6 or 7.
- `pending`  out  ADDR_W  unread record count.
- `ovf`  out  1  sticky overflow flag.
- `type_mask`  in  8  per-type pass mask; present only with `LOG_READER_FILTER_EN`.

## Operation

- `wr_q` is `log_wr_addr` registered one cycle. The reader only trusts `wr_q`, which guarantees the RAM write of index i has landed before i is read.
- `pending = wr_q - rd_ptr` mod 2^ADDR_W. Empty when it is 0.
- State machine:
  - IDLE: if not empty, drive `ram_rd_en=1` with `ram_rd_addr=rd_ptr` and go to WAIT; otherwise stay in IDLE.
  - WAIT: capture `ram_rd_data` into the output fields, set `rec_idx=rd_ptr`, increment `rd_ptr` (wrapping 2^ADDR_W-1 -> 0), go to HOLD.
  - HOLD: `rec_valid=1`. Output fields are stable until a cycle where `rec_valid && rec_ready`; that cycle is the transfer. Then go to IDLE.
- Decode: `rec_type=d[36:34]`, `rec_pc=d[33:18]`, `rec_addr=d[17:2]`, `rec_en=d[1]`, `rec_wr=d[0]`, `rec_bad=(d[36:35]==2'b11)`. Bad records are still presented.
- Overflow: when `wr_q` advances and the new `wr_q` equals `rd_ptr` while the old `pending` was nonzero, set `ovf=1`. At the same time force `rd_ptr` to the new `wr_q + 1`, so the oldest overwritten record is dropped. `ovf` is cleared only by reset or `clr_ram`.
- `clr_ram` has priority over all other activity in any state: `rd_ptr=0`, `wr_q=0`, `ovf=0`, `rec_valid=0`, state to IDLE. An in-flight read is discarded.

## Timing

- Reset values: state IDLE; `rd_ptr=0`, `wr_q=0`; `rec_valid=0`, `ram_rd_en=0`, `ram_rd_addr=0`; all `rec_*` fields 0; `pending=0`, `ovf=0`.
- Latency: `log_wr_addr` increments at edge E.
  - E+1: `wr_q` updates.
  - IDLE issues `ram_rd_en` in the cycle after E+1.
  - `rec_valid` rises 2 edges after the `ram_rd_en` cycle.
- Throughput: at most 1 record per 3 cycles while `rec_ready` is held high.
- `rec_valid` never drops without a transfer, except on reset or `clr_ram`.
- `pending` is combinational from registered `wr_q` and `rd_ptr`.
- Reset assertion mid-HOLD drops `rec_valid` immediately (asynchronous).

## Configuration

- `LOG_READER_FILTER_EN` defined:
  - `type_mask` port exists.
  - In WAIT, a record whose `type_mask[type]` is 0 is consumed silently: `rd_ptr` advances, no HOLD, return to IDLE.
- `LOG_READER_FILTER_EN` undefined:
  - No `type_mask` port.
  - Every record is presented.

## Test plan

- Writer logs 3 records (types 0, 1, 4) with `rec_ready=1` -> three transfers in order with `rec_idx` 0, 1, 2 and matching fields; `pending` returns to 0.
- `rec_ready=0` for 10 cycles with 1 record pending -> `rec_valid` stays high and all fields stay stable; exactly one transfer when ready rises.
- `rd_ptr=0xFFFF`, writer wraps to index 0 -> records read from 0xFFFF then 0x0000; `pending` is correct across the wrap.
- Writer laps reader (`pending` goes 0xFFFF -> wrap) -> `ovf=1`; `rd_ptr` jumps to `wr_q + 1`; the next record presented is the oldest survivor.
- `clr_ram` asserted in WAIT and again in HOLD -> `rec_valid=0`, `pending=0`, `ovf=0`, state IDLE the next cycle; no stale record appears.
- With `LOG_READER_FILTER_EN` and `type_mask=8'b0000_0010`, records of types 0, 1, 2 logged -> only the type-1 record is presented; `pending` ends at 0.

Source files
------------

// File: rtl/log_reader_if.sv
// Bundles the log RAM read port and the decoded record stream of log_reader.
// master: the reader side (issues RAM reads, sources records).
// slave:  the RAM/consumer side.
interface log_reader_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 37
);
   logic              ram_rd_en;
   logic [ADDR_W-1:0] ram_rd_addr;
   logic [DATA_W-1:0] ram_rd_data;
   logic              rec_valid;
   logic              rec_ready;
   logic [2:0]        rec_type;
   logic [15:0]       rec_pc;
   logic [15:0]       rec_addr;
   logic              rec_en;
   logic              rec_wr;
   logic [ADDR_W-1:0] rec_idx;
   logic              rec_bad;

   modport master (
      output ram_rd_en, ram_rd_addr,
      input  ram_rd_data,
      output rec_valid, rec_type, rec_pc, rec_addr, rec_en, rec_wr, rec_idx, rec_bad,
      input  rec_ready
   );

   modport slave (
      input  ram_rd_en, ram_rd_addr,
      output ram_rd_data,
      input  rec_valid, rec_type, rec_pc, rec_addr, rec_en, rec_wr, rec_idx, rec_bad,
      output rec_ready
   );
endinterface

// File: rtl/log_reader.sv
// Drain side of the attestation event log: walks the log RAM behind the writer's pointer,
// decodes each 37-bit record and offers it on a valid/ready stream. Detects the writer
// lapping the reader (sticky ovf) and drops the oldest overwritten record.
// Optional feature: LOG_READER_FILTER_EN adds a per-type pass mask (type_mask).
module log_reader #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 37
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr_ram,
   input  logic [ADDR_W-1:0] log_wr_addr,
`ifdef LOG_READER_FILTER_EN
   input  logic [7:0]        type_mask,
`endif
   log_reader_if.master      bus,
   output logic [ADDR_W-1:0] pending,
   output logic              ovf
);

   typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] wr_q, wr_d;
   logic              ovf_q, ovf_d;
   logic [2:0]        rec_type_q, rec_type_d;
   logic [15:0]       rec_pc_q, rec_pc_d;
   logic [15:0]       rec_addr_q, rec_addr_d;
   logic              rec_en_q, rec_en_d;
   logic              rec_wr_q, rec_wr_d;
   logic [ADDR_W-1:0] rec_idx_q, rec_idx_d;
   logic              rec_bad_q, rec_bad_d;

   logic       empty;
   logic       lap;
   logic       keep;
   logic [2:0] d_type;

   assign pending = wr_q - rd_ptr_q;
   assign empty   = (pending == '0);
   assign d_type  = bus.ram_rd_data[36:34];

   // Writer moved onto our read pointer with records still unread: oldest one is gone.
   assign lap = (log_wr_addr != wr_q) && (log_wr_addr == rd_ptr_q) && !empty;

`ifdef LOG_READER_FILTER_EN
   assign keep = type_mask[d_type];
`else
   assign keep = 1'b1;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         rd_ptr_q   <= '0;
         wr_q       <= '0;
         ovf_q      <= 1'b0;
         rec_type_q <= '0;
         rec_pc_q   <= '0;
         rec_addr_q <= '0;
         rec_en_q   <= 1'b0;
         rec_wr_q   <= 1'b0;
         rec_idx_q  <= '0;
         rec_bad_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_q       <= wr_d;
         ovf_q      <= ovf_d;
         rec_type_q <= rec_type_d;
         rec_pc_q   <= rec_pc_d;
         rec_addr_q <= rec_addr_d;
         rec_en_q   <= rec_en_d;
         rec_wr_q   <= rec_wr_d;
         rec_idx_q  <= rec_idx_d;
         rec_bad_q  <= rec_bad_d;
      end
   end

   // Next-state: read when non-empty, capture, then hold until the consumer takes it
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (!empty) state_d = StWait;
         StWait:  state_d = keep ? StHold : StIdle;
         StHold:  if (bus.rec_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (clr_ram) state_d = StIdle;
   end

   // Pointer, overflow and record-field updates
   always_comb begin
      wr_d       = log_wr_addr;
      rd_ptr_d   = rd_ptr_q;
      ovf_d      = ovf_q;
      rec_type_d = rec_type_q;
      rec_pc_d   = rec_pc_q;
      rec_addr_d = rec_addr_q;
      rec_en_d   = rec_en_q;
      rec_wr_d   = rec_wr_q;
      rec_idx_d  = rec_idx_q;
      rec_bad_d  = rec_bad_q;
      if (state_q == StWait) begin
         // Filtered records still advance the pointer; they are just never presented.
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         if (keep) begin
            rec_type_d = d_type;
            rec_pc_d   = bus.ram_rd_data[33:18];
            rec_addr_d = bus.ram_rd_data[17:2];
            rec_en_d   = bus.ram_rd_data[1];
            rec_wr_d   = bus.ram_rd_data[0];
            rec_idx_d  = rd_ptr_q;
            rec_bad_d  = (bus.ram_rd_data[36:35] == 2'b11);
         end
      end
      if (lap) begin
         ovf_d    = 1'b1;
         rd_ptr_d = log_wr_addr + ADDR_W'(1);
      end
      if (clr_ram) begin
         wr_d     = '0;
         rd_ptr_d = '0;
         ovf_d    = 1'b0;
      end
   end

   // Outputs decoded from the current state and registered fields
   always_comb begin
      bus.ram_rd_en   = (state_q == StIdle) && !empty && !clr_ram;
      bus.ram_rd_addr = rd_ptr_q;
      bus.rec_valid   = (state_q == StHold);
      bus.rec_type    = rec_type_q;
      bus.rec_pc      = rec_pc_q;
      bus.rec_addr    = rec_addr_q;
      bus.rec_en      = rec_en_q;
      bus.rec_wr      = rec_wr_q;
      bus.rec_idx     = rec_idx_q;
      bus.rec_bad     = rec_bad_q;
      ovf             = ovf_q;
   end

endmodule
